// File: rtl/z80_bus_arbiter_if.sv
// z80_bus_arbiter_if
//   Handshake bundle between the Z80 bus arbiter and its environment
//   (DMA requester, z80 core BUSRQ/BUSAK pins, error clear).
//   master : arbiter side (drives grant/busrq/status, reads requests)
//   slave  : environment side (drives requests/ack, reads grant/status)
interface z80_bus_arbiter_if;
  logic cen;
  logic dma_req;
  logic dma_done;
  logic dma_gnt;
  logic busrq_n;
  logic busak_n;
  logic preempt;
  logic err_timeout;
  logic err_lost;
  logic err_clr;
  logic busy;

  modport master (
    input  cen, dma_req, dma_done, busak_n, err_clr,
    output dma_gnt, busrq_n, preempt, err_timeout, err_lost, busy
  );

  modport slave (
    output cen, dma_req, dma_done, busak_n, err_clr,
    input  dma_gnt, busrq_n, preempt, err_timeout, err_lost, busy
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter
//   Shares the Z80 external bus between the CPU and one DMA requester via
//   BUSRQ/BUSAK, with an ack timeout, a grant hold limit and a minimum CPU
//   ownership gap after each release.
// Ports
//   clk    in  single clock (same as the z80 core)
//   reset  in  asynchronous, active-high reset
//   bus    z80_bus_arbiter_if.master: cen, dma_req, dma_done, busak_n,
//          err_clr in; dma_gnt, busrq_n, preempt, err_timeout, err_lost,
//          busy out (all outputs registered)
//
// state     | meaning
// S_IDLE    | CPU owns bus, waiting for dma_req
// S_REQ     | busrq_n low, waiting for busak_n (bounded by ACK_TIMEOUT)
// S_GRANT   | requester owns bus (bounded by HOLD_MAX)
// S_RELEASE | busrq_n high, waiting for core to take the bus back
// S_GAP     | CPU guaranteed MIN_GAP cycles before a new request
module z80_bus_arbiter #(
  parameter int ACK_TIMEOUT = 64,
  parameter int HOLD_MAX    = 256,
  parameter int MIN_GAP     = 4
) (
  input  logic              clk,
  input  logic              reset,
  z80_bus_arbiter_if.master bus
);

  // One shared counter: only one phase is ever being timed, and it is
  // cleared on every state change.
  localparam int CMAX_AH = (ACK_TIMEOUT > HOLD_MAX) ? ACK_TIMEOUT : HOLD_MAX;
  localparam int CMAX    = (CMAX_AH > MIN_GAP) ? CMAX_AH : MIN_GAP;
  localparam int CW      = $clog2(CMAX + 1);

  localparam logic [CW-1:0] L_ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] L_HOLD_LAST = CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] L_GAP_LAST  = CW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [CW-1:0] L_CNT_SAT   = CW'(CMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GRANT, S_RELEASE, S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busrq_n, r_dma_gnt, r_preempt, r_err_timeout, r_err_lost, r_busy;

  state_t w_state_nxt;
  logic   w_set_tmo, w_set_lost, w_preempt;

  // With no gap configured the CPU-side return path skips S_GAP entirely.
  localparam state_t L_AFTER_RELEASE = (MIN_GAP == 0) ? S_IDLE : S_GAP;

  always_comb begin
    w_state_nxt = r_state;
    w_set_tmo   = 1'b0;
    w_set_lost  = 1'b0;
    w_preempt   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.dma_req) w_state_nxt = S_REQ;
      S_REQ: begin
        // A grant beats a same-cycle timeout; a withdrawn request is not an error.
        if (!bus.busak_n)              w_state_nxt = S_GRANT;
        else if (!bus.dma_req)         w_state_nxt = S_RELEASE;
        else if (r_cnt == L_ACK_LAST) begin
          w_state_nxt = S_RELEASE;
          w_set_tmo   = 1'b1;
        end
      end
      S_GRANT: begin
        if (bus.busak_n) begin
          w_state_nxt = L_AFTER_RELEASE;
          w_set_lost  = 1'b1;
        end else if (bus.dma_done || !bus.dma_req) begin
          w_state_nxt = S_RELEASE;
        end else if (r_cnt == L_HOLD_LAST) begin
          w_state_nxt = S_RELEASE;
          w_preempt   = 1'b1;
        end
      end
      S_RELEASE: if (bus.busak_n) w_state_nxt = L_AFTER_RELEASE;
      S_GAP:     if (r_cnt == L_GAP_LAST) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_busrq_n     <= 1'b1;
      r_dma_gnt     <= 1'b0;
      r_preempt     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_lost    <= 1'b0;
      r_busy        <= 1'b0;
    end else if (bus.cen) begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != L_CNT_SAT) r_cnt <= r_cnt + 1'b1;
      r_busrq_n <= !(w_state_nxt == S_REQ || w_state_nxt == S_GRANT);
      r_dma_gnt <= (w_state_nxt == S_GRANT);
      r_preempt <= w_preempt;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (bus.err_clr) begin
        r_err_timeout <= 1'b0;
        r_err_lost    <= 1'b0;
      end else begin
        r_err_timeout <= r_err_timeout | w_set_tmo;
        r_err_lost    <= r_err_lost | w_set_lost;
      end
    end
  end

  assign bus.busrq_n     = r_busrq_n;
  assign bus.dma_gnt     = r_dma_gnt;
  assign bus.preempt     = r_preempt;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_lost    = r_err_lost;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter (ACK_TIMEOUT=8, HOLD_MAX=16, MIN_GAP=4).
// Expected output vectors {busrq_n, dma_gnt, preempt, err_timeout, err_lost, busy}
// are queued with each stimulus step and compared after the clock edge.
module tb_z80_bus_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  z80_bus_arbiter_if bus ();

  z80_bus_arbiter #(.ACK_TIMEOUT(8), .HOLD_MAX(16), .MIN_GAP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [5:0] obs;
  assign obs = {bus.busrq_n, bus.dma_gnt, bus.preempt, bus.err_timeout, bus.err_lost, bus.busy};

  logic [5:0] q_exp[$];
  string      q_tag[$];
  int         n_cmp = 0;
  int         n_mis = 0;

  task automatic check_front();
    logic [5:0] e;
    string      t;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  // One clock step with the currently driven inputs.
  task automatic step(input string tag, input logic [5:0] e);
    q_exp.push_back(e);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic steps(input int n, input string tag, input logic [5:0] e);
    for (int i = 0; i < n; i++) step(tag, e);
  endtask

  task automatic drive(input logic req, input logic done, input logic ak_n,
                       input logic en, input logic clr);
    bus.dma_req  = req;
    bus.dma_done = done;
    bus.busak_n  = ak_n;
    bus.cen      = en;
    bus.err_clr  = clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 1, 1, 0);
    #12;
    q_exp.push_back(6'b100000); q_tag.push_back("reset_state");
    check_front();
    @(posedge clk); #1;
    reset = 1'b0;
    steps(2, "idle", 6'b100000);

    // 1: ack after 3 REQ cycles, done ends grant, 4-cycle gap
    drive(1, 0, 1, 1, 0);
    steps(3, "t1_req", 6'b000001);
    drive(1, 0, 0, 1, 0);
    steps(7, "t1_gnt", 6'b010001);
    drive(1, 1, 0, 1, 0);
    step("t1_done_rel", 6'b100001);
    drive(0, 0, 0, 1, 0);
    step("t1_rel_wait", 6'b100001);
    drive(0, 0, 1, 1, 0);
    steps(4, "t1_gap", 6'b100001);
    step("t1_idle", 6'b100000);

    // 2: no ack -> busrq_n low exactly 8 cycles, err_timeout, then clear
    drive(1, 0, 1, 1, 0);
    steps(8, "t2_req", 6'b000001);
    step("t2_timeout", 6'b100101);
    drive(0, 0, 1, 1, 0);
    steps(4, "t2_gap", 6'b100101);
    step("t2_idle", 6'b100100);
    drive(0, 0, 1, 1, 1);
    step("t2_clr", 6'b100000);

    // 3: hold limit -> 16 grant cycles, one preempt, gap ignores held req
    drive(1, 0, 1, 1, 0);
    step("t3_req", 6'b000001);
    drive(1, 0, 0, 1, 0);
    steps(16, "t3_gnt", 6'b010001);
    step("t3_preempt", 6'b101001);
    step("t3_rel", 6'b100001);
    drive(1, 0, 1, 1, 0);
    steps(4, "t3_gap_req_ignored", 6'b100001);
    step("t3_idle", 6'b100000);
    step("t3_rereq", 6'b000001);
    drive(0, 0, 1, 1, 0);
    step("t3_drop_rel", 6'b100001);
    steps(4, "t3_gap2", 6'b100001);
    step("t3_idle2", 6'b100000);

    // 4: busak_n lost mid-grant; clear beats same-cycle set
    drive(1, 0, 1, 1, 0);
    step("t4_req", 6'b000001);
    drive(1, 0, 0, 1, 0);
    steps(2, "t4_gnt", 6'b010001);
    drive(1, 0, 1, 1, 0);
    step("t4_lost", 6'b100011);
    drive(0, 0, 1, 1, 0);
    steps(3, "t4_gap", 6'b100011);
    step("t4_idle", 6'b100010);
    drive(0, 0, 1, 1, 1);
    step("t4_clr", 6'b100000);
    drive(1, 0, 1, 1, 0);
    step("t4_req2", 6'b000001);
    drive(1, 0, 0, 1, 0);
    step("t4_gnt2", 6'b010001);
    drive(1, 0, 1, 1, 1);
    step("t4_lost_clr_same", 6'b100001);
    drive(0, 0, 1, 1, 0);
    steps(3, "t4_gap2", 6'b100001);
    step("t4_idle2", 6'b100000);

    // 5: cen freezes grant, preempt pulse and gap
    drive(1, 0, 1, 1, 0);
    step("t5_req", 6'b000001);
    drive(1, 0, 0, 1, 0);
    steps(6, "t5_gnt_a", 6'b010001);
    drive(1, 1, 1, 0, 1);
    steps(5, "t5_frozen_gnt", 6'b010001);
    drive(1, 0, 0, 1, 0);
    steps(10, "t5_gnt_b", 6'b010001);
    step("t5_preempt", 6'b101001);
    drive(1, 0, 0, 0, 0);
    steps(5, "t5_frozen_preempt", 6'b101001);
    drive(1, 0, 0, 1, 0);
    step("t5_rel", 6'b100001);
    drive(0, 0, 1, 1, 0);
    steps(2, "t5_gap_a", 6'b100001);
    drive(1, 0, 1, 0, 0);
    steps(5, "t5_frozen_gap", 6'b100001);
    drive(0, 0, 1, 1, 0);
    steps(2, "t5_gap_b", 6'b100001);
    step("t5_idle", 6'b100000);

    // 6: async reset mid-grant, then normal re-arbitration
    drive(1, 0, 1, 1, 0);
    step("t6_req", 6'b000001);
    drive(1, 0, 0, 1, 0);
    steps(3, "t6_gnt", 6'b010001);
    #2;
    reset = 1'b1;
    #1;
    q_exp.push_back(6'b100000); q_tag.push_back("t6_async_reset");
    check_front();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 0, 1, 1, 0);
    step("t6_req_after", 6'b000001);
    drive(1, 0, 0, 1, 0);
    step("t6_gnt_after", 6'b010001);
    drive(1, 1, 0, 1, 0);
    step("t6_done_after", 6'b100001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
